// File: rtl/fpu_cmp_arbiter_if.sv
// rtl/fpu_cmp_arbiter_if.sv - request/result channel bundle for the shared compare/min-max unit
interface fpu_cmp_arbiter_if #(
    parameter int XLEN = 32
);
    logic            req0_valid_i;
    logic            req0_ready_o;
    logic [2:0]      req0_op_i;
    logic [XLEN-1:0] req0_a_i;
    logic [XLEN-1:0] req0_b_i;
    logic            req1_valid_i;
    logic            req1_ready_o;
    logic [2:0]      req1_op_i;
    logic [XLEN-1:0] req1_a_i;
    logic [XLEN-1:0] req1_b_i;
    logic            res_valid_o;
    logic            res_ready_i;
    logic [XLEN-1:0] res_data_o;
    logic            res_tag_o;
    logic            res_nv_o;
    logic            nv_sticky_o;
    logic            nv_clear_i;

    modport slave (
        input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
        input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
        input  res_ready_i, nv_clear_i,
        output req0_ready_o, req1_ready_o,
        output res_valid_o, res_data_o, res_tag_o, res_nv_o, nv_sticky_o
    );

    modport master (
        output req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
        output req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
        output res_ready_i, nv_clear_i,
        input  req0_ready_o, req1_ready_o,
        input  res_valid_o, res_data_o, res_tag_o, res_nv_o, nv_sticky_o
    );
endinterface

// File: rtl/fpu_cmp_arbiter.sv
// rtl/fpu_cmp_arbiter.sv - round-robin shared binary32 compare/min/max with a one-entry result register
module fpu_cmp_arbiter #(
    parameter int XLEN = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    fpu_cmp_arbiter_if.slave   bus
);
    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_prio;
    logic [XLEN-1:0] r_data;
    logic            r_tag;
    logic            r_nv;
    logic            r_sticky;

    logic            w_any_req;
    logic            w_winner;
    logic            w_can_load;
    logic            w_accept;
    logic [2:0]      w_op;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [XLEN:0]   w_res;

    // Returns {nv, data}; zeros of either sign are equal, subnormals order by raw bits.
    function automatic logic [XLEN:0] fp_cmp(input logic [2:0] op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
        logic nan_a, nan_b, snan_a, snan_b, any_nan, any_snan;
        logic both_zero, eq, lt, min_is_a;
        logic [XLEN:0] res;
        nan_a     = (&a[30:23]) && (|a[22:0]);
        nan_b     = (&b[30:23]) && (|b[22:0]);
        snan_a    = nan_a && !a[22];
        snan_b    = nan_b && !b[22];
        any_nan   = nan_a || nan_b;
        any_snan  = snan_a || snan_b;
        both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
        eq        = both_zero || (a == b);
        if (a[31] != b[31])
            lt = a[31] && !both_zero;
        else if (a[31])
            lt = a[30:0] > b[30:0];
        else
            lt = a[30:0] < b[30:0];
        // Differing signs settle min/max by sign alone, which also orders -0 below +0.
        min_is_a = (a[31] != b[31]) ? a[31] : (lt || eq);
        res = '0;
        case (op)
            3'b000: res = {any_nan, {(XLEN-1){1'b0}}, !any_nan && (lt || eq)};
            3'b001: res = {any_nan, {(XLEN-1){1'b0}}, !any_nan && lt};
            3'b010: res = {any_snan, {(XLEN-1){1'b0}}, !any_nan && eq};
            3'b011, 3'b100: begin
                res[XLEN] = any_snan;
                if (nan_a && nan_b)
                    res[XLEN-1:0] = XLEN'(32'h7FC0_0000);
                else if (nan_a)
                    res[XLEN-1:0] = b;
                else if (nan_b)
                    res[XLEN-1:0] = a;
                else if (op[2])
                    res[XLEN-1:0] = min_is_a ? b : a;
                else
                    res[XLEN-1:0] = min_is_a ? a : b;
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    assign w_any_req  = bus.req0_valid_i || bus.req1_valid_i;
    assign w_winner   = (bus.req0_valid_i && bus.req1_valid_i) ? r_prio : bus.req1_valid_i;
    assign w_can_load = (r_state == S_EMPTY) || bus.res_ready_i;
    assign w_accept   = reset_i && w_any_req && w_can_load;
    assign w_op       = w_winner ? bus.req1_op_i : bus.req0_op_i;
    assign w_a        = w_winner ? bus.req1_a_i  : bus.req0_a_i;
    assign w_b        = w_winner ? bus.req1_b_i  : bus.req0_b_i;
    assign w_res      = fp_cmp(w_op, w_a, w_b);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            r_state <= S_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL:  if (bus.res_ready_i && !w_accept) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        bus.req0_ready_o = w_accept && !w_winner;
        bus.req1_ready_o = w_accept && w_winner;
        bus.res_valid_o  = (r_state == S_FULL);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_prio   <= 1'b0;
            r_data   <= '0;
            r_tag    <= 1'b0;
            r_nv     <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            if (w_accept) begin
                r_prio <= !w_winner;
                r_data <= w_res[XLEN-1:0];
                r_tag  <= w_winner;
                r_nv   <= w_res[XLEN];
            end
            if (w_accept && w_res[XLEN])
                r_sticky <= 1'b1;
            else if (bus.nv_clear_i)
                r_sticky <= 1'b0;
        end
    end

    assign bus.res_data_o  = r_data;
    assign bus.res_tag_o   = r_tag;
    assign bus.res_nv_o    = r_nv;
    assign bus.nv_sticky_o = r_sticky;
endmodule

// File: doc/fpu_cmp_arbiter.md
# fpu_cmp_arbiter

Shares one single-precision compare/min-max datapath between two requesters: port 0 is the FPU issue path and port 1 is the auxiliary FP unit. Each requester has a valid/ready request channel. Requests are granted round-robin, operands are unpacked, and the result is registered with a requester tag and IEEE flags. Results leave on one valid/ready result channel. The block sits between FPU decode/issue and the FP writeback mux.

## Interface
Parameters:
- XLEN, 32, operand and result width (binary32 only).

Ports:
- clk_i  in  1  core clock.
- reset_i  in  1  asynchronous, active-low reset.
- req0_valid_i / req1_valid_i  in  1  request valid, per port.
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle when valid&ready.
- req0_op_i / req1_op_i  in  3  000 FLE, 001 FLT, 010 FEQ, 011 FMIN, 100 FMAX; 101–111 reserved.
- req0_a_i, req0_b_i / req1_a_i, req1_b_i  in  XLEN  raw binary32 operands.
- res_valid_o  out  1  result register holds data.
- res_ready_i  in  1  consumer accepts the result.
- res_data_o  out  XLEN  result: a compare gives a zero-extended bit; min/max gives a binary32 value.
- res_tag_o  out  1  requester id of the result (0/1).
- res_nv_o  out  1  invalid flag for this result.
- nv_sticky_o  out  1  OR of all res_nv since the last clear.
- nv_clear_i  in  1  synchronous clear of nv_sticky_o.

## Operation
- Unpack each operand:
  - sign = bit31, exp = bits30:23, frac = bits22:0.
  - NaN = exp==FF and frac!=0; sNaN = NaN and frac[22]==0.
  - Zero = exp==0 and frac==0.
- Ordering is IEEE-correct:
  - Sign-magnitude compare, with magnitude order inverted when both operands are negative.
  - −0 == +0 for FEQ/FLT/FLE.
  - Subnormals compare by raw bits (no flush).
- FEQ/FLT/FLE:
  - Result is 1/0; it is 0 if either operand is NaN.
  - FLT/FLE: nv=1 if either operand is NaN.
  - FEQ: nv=1 only if either operand is sNaN.
- FMIN/FMAX:
  - Return the smaller/larger operand.
  - For equal-magnitude zeros, −0 < +0, so FMIN(+0,−0) = −0 and FMAX = +0.
  - If one operand is NaN, return the other operand.
  - If both are NaN, return 0x7FC00000.
  - nv=1 if either operand is sNaN.
- Reserved op: result 0, nv=0, and the request is still accepted.
- Arbitration: the round-robin pointer prio (reset 0) decides between simultaneous valid requests.
  - Only one requester valid: it wins regardless of prio.
  - Both valid: port prio wins.
  - After any grant, prio = ~winner.
- State machine, based on the result register:
  - EMPTY (res_valid_o=0): accept the winner; go to FULL next cycle.
  - FULL & res_ready_i=1: accept a new winner the same cycle (back-to-back) and stay FULL; with no request, go to EMPTY.
  - FULL & res_ready_i=0: hold data, tag and nv stable; both req_ready_o=0.
- req_ready_o:
  - Asserted only to the winning port, and only when (EMPTY or res_ready_i).
  - Combinational from the valid inputs, prio, res_valid_o and res_ready_i.
- nv_sticky:
  - Set on the cycle a result with nv=1 is loaded.
  - nv_clear_i clears it; if a clear and a set coincide, the set wins.

## Timing
- Reset values: res_valid_o=0, res_data_o=0, res_tag_o=0, res_nv_o=0, nv_sticky_o=0, prio=0. req*_ready_o is 0 during reset.
- Latency is 1 cycle: a request accepted at edge N presents its result from after edge N until the handshake completes.
- Throughput is 1 result/cycle while res_ready_i=1.
- Reset asserted mid-operation: the pending result is discarded immediately and the requester must reissue.
- A request's operands are sampled only on the accepting edge; the requester may change them afterwards.

## Test plan
- Port0 FLT a=0xBF800000 (−1), b=0x3F800000 (+1) -> next cycle res_data=1, tag=0, nv=0. Repeat with FLT −2 vs −1 (0xC0000000, 0xBF800000) -> 1.
- FEQ +0 (0x00000000) vs −0 (0x80000000) -> 1. Same operands with FMIN -> 0x80000000; with FMAX -> 0x00000000.
- NaN handling:
  - FEQ with qNaN 0x7FC00000 vs 1.0 -> data=0, nv=0.
  - FLE with the same operands -> data=0, nv=1, nv_sticky=1.
  - FMIN with sNaN 0x7F800001 vs 2.0 -> 0x40000000, nv=1.
  - FMAX with both qNaN -> 0x7FC00000.
- Both ports valid for 4 cycles with res_ready=1 -> grants alternate 0,1,0,1, tags match, and nothing is dropped.
- res_ready_i=0 for 3 cycles while FULL -> outputs stable, both ready=0. Release -> the queued winner is accepted on the same edge the held result drains.
- reset_i low while FULL with req valid -> res_valid_o drops immediately, nv_sticky=0, prio=0. nv_clear_i coinciding with an nv=1 load -> sticky stays 1.
